arith_display_unit: RTL and testbench



---
 rtl/arith_display_unit.sv | 157 +++++++++++++++
 tb/tb_arith_display_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_display_unit.sv
// Sign-magnitude add/sub/mul/div unit with one cycle of latency.
// The result magnitude is also shown as three leading-zero-blanked seven-segment digits.
module arith_display_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic [1:0] op,
  output logic [8:0] result,
  output logic       sign,
  output logic       zero,
  output logic       div_by_zero,
  output logic       overflow,
  output logic       out_valid,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Shift-and-add-3: hundreds/tens/ones BCD digits of an 8-bit value
  function automatic logic [11:0] bin_to_bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] > 4'd4) sh[11:8] = sh[11:8] + 4'd3;
      else sh[11:8] = sh[11:8];
      if (sh[15:12] > 4'd4) sh[15:12] = sh[15:12] + 4'd3;
      else sh[15:12] = sh[15:12];
      if (sh[19:16] > 4'd4) sh[19:16] = sh[19:16] + 4'd3;
      else sh[19:16] = sh[19:16];
      sh = {sh[18:0], 1'b0};
    end
    bin_to_bcd = sh[19:8];
  endfunction

  logic [7:0]  w_mag_a, w_mag_b, w_mag;
  logic        w_sign_b, w_sign, w_ovf, w_dbz;
  logic [8:0]  w_sum;
  logic [15:0] w_prod;
  logic [11:0] w_bcd;
  logic [6:0]  w_hex0, w_hex1, w_hex2;

  logic [8:0]  r_result;
  logic        r_zero, r_dbz, r_ovf, r_valid;
  logic [6:0]  r_hex0, r_hex1, r_hex2;

  // Next result, flags and digit patterns from the current operands
  always_comb begin
    w_mag_a  = a[7:0];
    w_mag_b  = b[7:0];
    w_sign_b = (op == OP_SUB) ? ~b[8] : b[8];
    w_sum    = {1'b0, w_mag_a} + {1'b0, w_mag_b};
    w_prod   = {8'd0, w_mag_a} * {8'd0, w_mag_b};
    w_mag    = 8'd0;
    w_sign   = 1'b0;
    w_ovf    = 1'b0;
    w_dbz    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        if (a[8] == w_sign_b) begin
          w_mag  = w_sum[7:0];
          w_sign = a[8];
          w_ovf  = w_sum[8];
        end else if (w_mag_a >= w_mag_b) begin
          w_mag  = w_mag_a - w_mag_b;
          w_sign = a[8];
        end else begin
          w_mag  = w_mag_b - w_mag_a;
          w_sign = w_sign_b;
        end
      end
      OP_MUL: begin
        w_mag  = w_prod[7:0];
        w_sign = a[8] ^ b[8];
        w_ovf  = (w_prod[15:8] != 8'd0);
      end
      OP_DIV: begin
        if (w_mag_b == 8'd0) begin
          w_dbz = 1'b1;
        end else begin
          w_mag  = w_mag_a / w_mag_b;
          w_sign = a[8] ^ b[8];
        end
      end
      default: begin
        w_mag = 8'd0;
      end
    endcase
    // A zero magnitude is always reported as positive
    if (w_mag == 8'd0) w_sign = 1'b0;
    else w_sign = w_sign;

    w_bcd  = bin_to_bcd(w_mag);
    w_hex0 = seg7(w_bcd[3:0]);
    w_hex1 = (w_bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(w_bcd[7:4]);
    w_hex2 = (w_bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(w_bcd[11:8]);
  end

  // Output register: reset wins, otherwise capture on in_valid and hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 9'h000;
      r_zero   <= 1'b1;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_hex0   <= 7'b1000000;
      r_hex1   <= SEG_BLANK;
      r_hex2   <= SEG_BLANK;
    end else if (in_valid) begin
      r_result <= {w_sign, w_mag};
      r_zero   <= (w_mag == 8'd0);
      r_dbz    <= w_dbz;
      r_ovf    <= w_ovf;
      r_valid  <= 1'b1;
      r_hex0   <= w_hex0;
      r_hex1   <= w_hex1;
      r_hex2   <= w_hex2;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign result      = r_result;
  assign sign        = r_result[8];
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
  assign out_valid   = r_valid;
  assign hex0        = r_hex0;
  assign hex1        = r_hex1;
  assign hex2        = r_hex2;

endmodule

// File: tb/tb_arith_display_unit.sv
// Self-checking bench for arith_display_unit: directed cases plus randomized
// operations compared against a signed-integer reference model.
module tb_arith_display_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] a, b;
  logic [1:0] op;
  logic [8:0] result;
  logic       sign, zero, div_by_zero, overflow, out_valid;
  logic [6:0] hex0, hex1, hex2;

  int errors = 0;
  int checks = 0;

  arith_display_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .result(result), .sign(sign), .zero(zero), .div_by_zero(div_by_zero),
    .overflow(overflow), .out_valid(out_valid),
    .hex0(hex0), .hex1(hex1), .hex2(hex2)
  );

  always #5 clk = ~clk;

  // {result, sign, zero, div_by_zero, overflow, out_valid, hex2, hex1, hex0}
  logic [34:0] obs;
  assign obs = {result, sign, zero, div_by_zero, overflow, out_valid, hex2, hex1, hex0};

  localparam logic [34:0] RESET_EXP = {9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                       7'b1111111, 7'b1111111, 7'b1000000};

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  function automatic logic [34:0] model(input logic [8:0] ia, input logic [8:0] ib,
                                        input logic [1:0] iop);
    int sa, sb, t, m, mag;
    logic dbz, ovf, neg;
    logic [6:0] h0, h1, h2;
    sa = ia[8] ? -int'(ia[7:0]) : int'(ia[7:0]);
    sb = ib[8] ? -int'(ib[7:0]) : int'(ib[7:0]);
    dbz = 1'b0;
    t = 0;
    case (iop)
      2'd0: t = sa + sb;
      2'd1: t = sa - sb;
      2'd2: t = sa * sb;
      default: begin
        if (sb == 0) dbz = 1'b1;
        else t = sa / sb;
      end
    endcase
    m   = (t < 0) ? -t : t;
    ovf = (iop != 2'd3) && (m > 255);
    mag = m % 256;
    neg = (t < 0) && (mag != 0);
    h0  = seg_tab[mag % 10];
    h1  = (mag < 10)  ? 7'b1111111 : seg_tab[(mag / 10) % 10];
    h2  = (mag < 100) ? 7'b1111111 : seg_tab[mag / 100];
    return {neg, mag[7:0], neg, (mag == 0), dbz, ovf, 1'b1, h2, h1, h0};
  endfunction

  task automatic apply(input logic [8:0] ia, input logic [8:0] ib, input logic [1:0] iop);
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_EXP) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, RESET_EXP);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [34:0] held;
    apply(9'h003, 9'h102, 2'b00);
    checks++;
    if ({result, sign, out_valid, hex2, hex1, hex0} !==
        {9'h001, 1'b0, 1'b1, 7'b1111111, 7'b1111111, 7'b1111001}) begin
      errors++;
      $display("FAIL add_mixed: got res=%h sign=%b ov=%b hex=%b/%b/%b", result, sign,
               out_valid, hex2, hex1, hex0);
    end
    held = obs;
    idle();
    checks++;
    if (obs !== {held[34:22], 1'b0, held[20:0]}) begin
      errors++;
      $display("FAIL add_pulse: got %h expected %h", obs, {held[34:22], 1'b0, held[20:0]});
    end
  endtask

  task automatic test_sub();
    apply(9'h001, 9'h003, 2'b01);
    checks++;
    if ({result, sign, zero} !== {9'h102, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_neg: got res=%h sign=%b zero=%b expected 102/1/0", result, sign, zero);
    end
    apply(9'h005, 9'h005, 2'b01);
    checks++;
    if ({result, sign, zero, hex0} !== {9'h000, 1'b0, 1'b1, 7'b1000000}) begin
      errors++;
      $display("FAIL sub_zero: got res=%h sign=%b zero=%b hex0=%b", result, sign, zero, hex0);
    end
  endtask

  task automatic test_mul();
    apply(9'h0C8, 9'h002, 2'b10);
    checks++;
    if ({result, overflow, hex2, hex1, hex0} !==
        {9'h090, 1'b1, 7'b1111001, 7'b0011001, 7'b0011001}) begin
      errors++;
      $display("FAIL mul_ovf: got res=%h ovf=%b hex=%b/%b/%b", result, overflow, hex2, hex1, hex0);
    end
    apply(9'h103, 9'h103, 2'b10);
    checks++;
    if ({result, sign, overflow} !== {9'h009, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_negneg: got res=%h sign=%b ovf=%b expected 009/0/0", result, sign, overflow);
    end
  endtask

  task automatic test_div();
    apply(9'h107, 9'h002, 2'b11);
    checks++;
    if ({result, div_by_zero, overflow} !== {9'h103, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div_neg: got res=%h dbz=%b ovf=%b expected 103/0/0", result, div_by_zero, overflow);
    end
    apply(9'h007, 9'h100, 2'b11);
    checks++;
    if ({result, div_by_zero, zero, overflow} !== {9'h000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL div_zero: got res=%h dbz=%b zero=%b ovf=%b", result, div_by_zero, zero, overflow);
    end
    apply(9'h009, 9'h003, 2'b11);
    checks++;
    if ({result, div_by_zero} !== {9'h003, 1'b0}) begin
      errors++;
      $display("FAIL div_clear: got res=%h dbz=%b expected 003/0", result, div_by_zero);
    end
  endtask

  task automatic test_hold();
    logic [34:0] held;
    apply(9'h0FF, 9'h001, 2'b00);
    held = {obs[34:22], 1'b0, obs[20:0]};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 9'($urandom); b = 9'($urandom); op = 2'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (obs !== held) begin
        errors++;
        $display("FAIL hold[%0d]: got %h expected %h", i, obs, held);
      end
    end
  endtask

  task automatic test_reset_priority();
    apply(9'h0C8, 9'h003, 2'b10);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 9'h032; b = 9'h005; op = 2'b00;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_EXP) begin
      errors++;
      $display("FAIL reset_priority: got %h expected %h", obs, RESET_EXP);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] ra, rb;
    logic [1:0] rop;
    logic [34:0] exp;
    for (int i = 0; i < 10; i++) begin
      ra = 9'($urandom); rb = 9'($urandom); rop = 2'(i);
      exp = model(ra, rb, rop);
      apply(ra, rb, rop);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: a=%h b=%h op=%0d got %h expected %h", i, ra, rb, rop, obs, exp);
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [8:0] ra, rb;
    logic [1:0] rop;
    logic [34:0] exp;
    exp = obs;
    for (int i = 0; i < 300; i++) begin
      ra = {1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom)};
      rb = {1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom)};
      rop = 2'($urandom);
      @(negedge clk);
      a = ra; b = rb; op = rop;
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) exp = model(ra, rb, rop);
      else exp[21] = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h op=%0d v=%b got %h expected %h", i, ra, rb, rop,
                 in_valid, obs, exp);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 9'h000; b = 9'h000; op = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
